// File: rtl/line_buffer_3row.sv
// line_buffer_3row: turns a raster pixel stream into three vertically aligned rows
// (r-2, r-1, r) at the same column for a downstream 3x3 window stage. Two lines are
// kept in RAM; a column is emitted only once two earlier rows of the frame are stored.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL0 | row 0 of the frame arriving; store only, nothing emitted
// FILL1 | row 1 of the frame arriving; store only, nothing emitted
// RUN   | row >= 2; every accepted pixel emits (r-2, r-1, r) one cycle later
module line_buffer_3row #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             eol_out,
  output logic             eof_out
);

  localparam int CW = $clog2(PIC_WIDTH);
  localparam int RW = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

  state_t         state;
  state_t         cur_state;
  logic [CW-1:0]  col;
  logic [CW-1:0]  cur_col;
  logic [RW-1:0]  row;
  logic [RW-1:0]  cur_row;
  logic           last_col;
  logic           last_row;

  // ram_a holds row r-1, ram_b holds row r-2; both indexed by column
  logic [WIDTH-1:0] ram_a [PIC_WIDTH];
  logic [WIDTH-1:0] ram_b [PIC_WIDTH];

  // A sof pixel is always treated as (row 0, col 0) in FILL0, whatever came before
  always_comb begin
    cur_state = state;
    cur_col   = col;
    cur_row   = row;
    if (sof) begin
      cur_state = FILL0;
      cur_col   = '0;
      cur_row   = '0;
    end
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
  end

  // Line storage: shift the column down one row; nonblocking gives read-before-write
  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      ram_b[cur_col] <= ram_a[cur_col];
      ram_a[cur_col] <= din;
    end
  end

  // Position tracking, fill/run sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL0;
      col       <= '0;
      row       <= '0;
      valid_out <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (cur_state == RUN) begin
          valid_out <= 1'b1;
          dout1     <= ram_b[cur_col];
          dout2     <= ram_a[cur_col];
          dout3     <= din;
          eol_out   <= last_col;
          eof_out   <= last_col && last_row;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + 1'b1;
          case (cur_state)
            FILL0:   state <= FILL1;
            FILL1:   state <= RUN;
            default: state <= last_row ? FILL0 : RUN;
          endcase
        end else begin
          col   <= cur_col + 1'b1;
          row   <= cur_row;
          state <= cur_state;
        end
      end
    end
  end

endmodule
